trap_ctrl: RTL and testbench

//  Trap sequencer in front of the machine CSR unit (mtvec/mepc/mcause/mtval).
//  On an exception it takes the CSR port from the pipeline, writes mepc, mcause and mtval
//  in order, then reads mtvec and issues a one-cycle PC redirect. mret reads mepc and redirects.

---
 rtl/trap_ctrl.sv | 162 ++++++++++++++++
 tb/tb_trap_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl: trap sequencer sitting between the pipeline and the machine CSR unit.
// On an exception it owns the CSR port, writes mepc, mcause and mtval in turn, then
// reads mtvec and issues a one-cycle PC redirect. mret reads mepc and redirects.
// While idle, pipeline CSR accesses pass straight through.
// Optional feature macro: TRAP_VECTORED_EN (vectored interrupt targets when mtvec mode is 01).
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | pipeline owns the CSR port; accept exception or mret
// W_EPC   | write faulting PC to mepc
// W_CAUSE | write cause to mcause
// W_TVAL  | write trap value to mtval
// JUMP    | read mtvec, register the trap target
// R_EPC   | read mepc, register the mret target
module trap_ctrl #(
    parameter int unsigned      XLEN        = 32,
    parameter logic [XLEN-1:0]  MTVEC_ADDR  = 32'h305,
    parameter logic [XLEN-1:0]  MEPC_ADDR   = 32'h341,
    parameter logic [XLEN-1:0]  MCAUSE_ADDR = 32'h342,
    parameter logic [XLEN-1:0]  MTVAL_ADDR  = 32'h343
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exc_valid,
    input  logic [XLEN-1:0] exc_cause,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret_valid,
    input  logic [XLEN-1:0] cpu_csr_addr,
    input  logic [XLEN-1:0] cpu_csr_wdata,
    input  logic            cpu_csr_we,
    output logic [XLEN-1:0] cpu_csr_rdata,
    output logic [XLEN-1:0] csr_address,
    output logic [XLEN-1:0] csr_din,
    output logic            csr_we,
    input  logic [XLEN-1:0] csr_dout,
    output logic            stall,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_EPC   = 3'd1,
        W_CAUSE = 3'd2,
        W_TVAL  = 3'd3,
        JUMP    = 3'd4,
        R_EPC   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] cause_q, pc_q, tval_q;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [XLEN-1:0] direct_tgt, jump_tgt;

    assign direct_tgt = {csr_dout[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    // Vectored target: only interrupts (cause MSB set) with mtvec mode 01 get base + 4*cause.
    always_comb begin
        jump_tgt = direct_tgt;
        if ((csr_dout[1:0] == 2'b01) && cause_q[XLEN-1]) begin
            jump_tgt = direct_tgt + {cause_q[XLEN-3:0], 2'b00};
        end
    end
`else
    assign jump_tgt = direct_tgt;
`endif

    // State and redirect registers; reset aborts any sequence in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    // Capture the trap payload when an exception is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cause_q <= '0;
            pc_q    <= '0;
            tval_q  <= '0;
        end else if ((state_q == IDLE) && exc_valid) begin
            cause_q <= exc_cause;
            pc_q    <= exc_pc;
            tval_q  <= exc_tval;
        end
    end

    // Next state, CSR port mux and stall.
    always_comb begin
        state_d          = state_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        csr_address      = '0;
        csr_din          = '0;
        csr_we           = 1'b0;
        cpu_csr_rdata    = '0;
        stall            = 1'b1;
        case (state_q)
            IDLE: begin
                csr_address   = cpu_csr_addr;
                csr_din       = cpu_csr_wdata;
                csr_we        = cpu_csr_we;
                cpu_csr_rdata = csr_dout;
                stall         = 1'b0;
                // Exception has priority; a simultaneous mret is dropped.
                if (exc_valid) begin
                    state_d = W_EPC;
                    stall   = 1'b1;
                end else if (mret_valid) begin
                    state_d = R_EPC;
                    stall   = 1'b1;
                end
            end
            W_EPC: begin
                csr_address = MEPC_ADDR;
                csr_din     = pc_q;
                csr_we      = 1'b1;
                state_d     = W_CAUSE;
            end
            W_CAUSE: begin
                csr_address = MCAUSE_ADDR;
                csr_din     = cause_q;
                csr_we      = 1'b1;
                state_d     = W_TVAL;
            end
            W_TVAL: begin
                csr_address = MTVAL_ADDR;
                csr_din     = tval_q;
                csr_we      = 1'b1;
                state_d     = JUMP;
            end
            JUMP: begin
                csr_address      = MTVEC_ADDR;
                redirect_pc_d    = jump_tgt;
                redirect_valid_d = 1'b1;
                state_d          = IDLE;
            end
            R_EPC: begin
                csr_address      = MEPC_ADDR;
                redirect_pc_d    = direct_tgt;
                redirect_valid_d = 1'b1;
                state_d          = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: self-checking bench for trap_ctrl with a behavioural CSR unit.
module tb_trap_ctrl;

`ifdef TRAP_VECTORED_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid, mret_valid, cpu_csr_we;
    logic [31:0] exc_cause, exc_pc, exc_tval;
    logic [31:0] cpu_csr_addr, cpu_csr_wdata, cpu_csr_rdata;
    logic [31:0] csr_address, csr_din, csr_dout;
    logic        csr_we, stall, redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    trap_ctrl dut (
        .clk(clk), .rst(rst),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .mret_valid(mret_valid),
        .cpu_csr_addr(cpu_csr_addr), .cpu_csr_wdata(cpu_csr_wdata), .cpu_csr_we(cpu_csr_we),
        .cpu_csr_rdata(cpu_csr_rdata),
        .csr_address(csr_address), .csr_din(csr_din), .csr_we(csr_we), .csr_dout(csr_dout),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    // Behavioural CSR unit: keeps its contents across trap_ctrl reset.
    logic [31:0] m_mtvec = '0, m_mepc = '0, m_mcause = '0, m_mtval = '0;
    int unsigned cyc = 0;
    typedef struct { int unsigned cyc; logic [31:0] addr; logic [31:0] data; } wr_t;
    wr_t wlog[$];

    always @(posedge clk) begin
        if (csr_we) begin
            wlog.push_back('{cyc, csr_address, csr_din});
            case (csr_address)
                32'h305: m_mtvec  <= csr_din;
                32'h341: m_mepc   <= csr_din;
                32'h342: m_mcause <= csr_din;
                32'h343: m_mtval  <= csr_din;
                default: ;
            endcase
        end
        cyc <= cyc + 1;
    end

    always_comb begin
        csr_dout = '0;
        case (csr_address)
            32'h305: csr_dout = m_mtvec;
            32'h341: csr_dout = m_mepc;
            32'h342: csr_dout = m_mcause;
            32'h343: csr_dout = m_mtval;
            default: csr_dout = '0;
        endcase
    end

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        cpu_csr_addr = a; cpu_csr_wdata = d; cpu_csr_we = 1'b1;
        #1;
        chk("idle_pass_addr", csr_address, a);
        chk("idle_pass_we", {31'd0, csr_we}, 32'd1);
        chk("idle_pass_din", csr_din, d);
        @(negedge clk);
        cpu_csr_we = 1'b0; cpu_csr_wdata = '0;
        #1 chk("idle_readback", cpu_csr_rdata, d);
    endtask

    task automatic do_seq(input string nm, input bit e, input bit m, input logic [31:0] cause,
                          input logic [31:0] pc, input logic [31:0] tval,
                          input logic [31:0] exp_pc, input int lat);
        int unsigned c0;
        bit seen;
        logic [31:0] ea[3];
        logic [31:0] ed[3];
        ea = '{32'h341, 32'h342, 32'h343};
        ed = '{pc, cause, tval};
        @(negedge clk);
        exc_valid = e; mret_valid = m; exc_cause = cause; exc_pc = pc; exc_tval = tval;
        exp_q.push_back(exp_pc);
        wlog.delete();
        c0 = cyc;
        #1 chk({nm, ":stall_accept"}, {31'd0, stall}, 32'd1);
        seen = 1'b0;
        for (int n = 1; n <= 12 && !seen; n++) begin
            @(negedge clk);
            exc_valid = 1'b0; mret_valid = 1'b0;
            #1;
            if (redirect_valid) begin
                seen = 1'b1;
                chk({nm, ":latency"}, 32'(n), 32'(lat));
                chk({nm, ":stall_redirect"}, {31'd0, stall}, 32'd0);
                if (exp_q.size() > 0) chk({nm, ":redirect_pc"}, redirect_pc, exp_q.pop_front());
                else chk({nm, ":unexpected_redirect"}, 32'd1, 32'd0);
            end else if (n < lat) begin
                chk({nm, ":stall_busy"}, {31'd0, stall}, 32'd1);
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s:timeout no redirect within 12 cycles, expected at %0d", nm, lat);
        end
        if (e) begin
            chk({nm, ":num_writes"}, 32'(wlog.size()), 32'd3);
            if (wlog.size() == 3) begin
                for (int i = 0; i < 3; i++) begin
                    chk({nm, ":wr_addr"}, wlog[i].addr, ea[i]);
                    chk({nm, ":wr_data"}, wlog[i].data, ed[i]);
                    chk({nm, ":wr_cycle"}, wlog[i].cyc - c0, 32'(i + 1));
                end
            end
        end else begin
            chk({nm, ":num_writes"}, 32'(wlog.size()), 32'd0);
        end
        @(negedge clk);
        #1 chk({nm, ":single_redirect"}, {31'd0, redirect_valid}, 32'd0);
    endtask

    typedef struct {
        string       nm;
        bit          e;
        bit          m;
        logic [31:0] pre_a;
        logic [31:0] pre_d;
        logic [31:0] cause;
        logic [31:0] pc;
        logic [31:0] tval;
        logic [31:0] exp;
        int          lat;
    } vec_t;
    vec_t vt[9];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{"trap_basic",  1, 0, 32'h305, 32'h1000, 32'd2,        32'h80, 32'hDEAD, 32'h1000, 5};
        vt[1] = '{"mret_basic",  0, 1, 32'h341, 32'h84,   32'd0,        32'h0,  32'h0,    32'h84,   2};
        vt[2] = '{"exc_and_mret",1, 1, 32'h0,   32'h0,    32'd3,        32'h90, 32'h11,   32'h1000, 5};
        vt[3] = '{"vectored_irq",1, 0, 32'h305, 32'h1001, 32'h80000007, 32'h94, 32'h0,
                  (VEC ? 32'h101C : 32'h1000), 5};
        vt[4] = '{"mode01_sync", 1, 0, 32'h0,   32'h0,    32'd7,        32'h98, 32'h22,   32'h1000, 5};
        vt[5] = '{"mode11_irq",  1, 0, 32'h305, 32'h2003, 32'h80000001, 32'hA4, 32'h33,   32'h2000, 5};
        vt[6] = '{"mret_align",  0, 1, 32'h341, 32'h103,  32'd0,        32'h0,  32'h0,    32'h100,  2};
        vt[7] = '{"vector_wrap", 1, 0, 32'h305, 32'hFFFFFFFD, 32'h80000002, 32'hB0, 32'h44,
                  (VEC ? 32'h4 : 32'hFFFFFFFC), 5};
        vt[8] = '{"mret_after",  0, 1, 32'h0,   32'h0,    32'd0,        32'h0,  32'h0,    32'hB0,   2};

        rst = 1'b1;
        exc_valid = 0; mret_valid = 0; exc_cause = 0; exc_pc = 0; exc_tval = 0;
        cpu_csr_addr = 0; cpu_csr_wdata = 0; cpu_csr_we = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("reset_redirect_pc", redirect_pc, 32'd0);
        chk("reset_csr_we", {31'd0, csr_we}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            if (vt[i].pre_a != 32'h0) cpu_write(vt[i].pre_a, vt[i].pre_d);
            do_seq(vt[i].nm, vt[i].e, vt[i].m, vt[i].cause, vt[i].pc, vt[i].tval, vt[i].exp, vt[i].lat);
        end

        // Pipeline write to mtvec during W_CAUSE is masked; requests mid-sequence are dropped.
        begin
            bit seen;
            cpu_write(32'h305, 32'h1000);
            @(negedge clk);
            exc_valid = 1; exc_cause = 32'd4; exc_pc = 32'hC0; exc_tval = 32'h55;
            exp_q.push_back(32'h1000);
            seen = 1'b0;
            for (int n = 1; n <= 10 && !seen; n++) begin
                @(negedge clk);
                exc_valid = 0; mret_valid = 0;
                if (n == 2) begin
                    cpu_csr_addr = 32'h305; cpu_csr_wdata = 32'h2000; cpu_csr_we = 1'b1;
                    #1;
                    chk("masked:addr", csr_address, 32'h342);
                    chk("masked:din", csr_din, 32'd4);
                    chk("masked:rdata", cpu_csr_rdata, 32'd0);
                end else if (n == 3) begin
                    cpu_csr_we = 1'b0; cpu_csr_wdata = 32'h0;
                    exc_valid = 1; mret_valid = 1;
                    #1 chk("masked:stall_tval", {31'd0, stall}, 32'd1);
                end else begin
                    #1;
                end
                if (redirect_valid) begin
                    seen = 1'b1;
                    chk("masked:latency", 32'(n), 32'd5);
                    if (exp_q.size() > 0) chk("masked:redirect_pc", redirect_pc, exp_q.pop_front());
                end
            end
            if (!seen) begin
                checks++; errors++;
                $display("FAIL masked:timeout no redirect, expected at 5");
            end
            chk("masked:mtvec_kept", m_mtvec, 32'h1000);
            for (int n = 0; n < 5; n++) begin
                @(negedge clk);
                #1 chk("masked:dropped_req", {31'd0, redirect_valid}, 32'd0);
            end
            cpu_write(32'h305, 32'h2000);
            chk("idle_write:mtvec", m_mtvec, 32'h2000);
            do_seq("after_mtvec_write", 1, 0, 32'd5, 32'hC4, 32'h66, 32'h2000, 5);
        end

        // Reset asserted in W_TVAL aborts; earlier CSR writes stay, mtval untouched.
        begin
            logic [31:0] prev_tval;
            prev_tval = m_mtval;
            @(negedge clk);
            exc_valid = 1; exc_cause = 32'd9; exc_pc = 32'hD0; exc_tval = 32'hBEEF;
            @(negedge clk);
            exc_valid = 0;
            @(negedge clk);
            @(negedge clk);
            rst = 1'b1;
            #1;
            chk("rst_mid:stall", {31'd0, stall}, 32'd0);
            chk("rst_mid:csr_we", {31'd0, csr_we}, 32'd0);
            chk("rst_mid:redirect_valid", {31'd0, redirect_valid}, 32'd0);
            chk("rst_mid:redirect_pc", redirect_pc, 32'd0);
            @(negedge clk);
            rst = 1'b0;
            chk("rst_mid:mepc_kept", m_mepc, 32'hD0);
            chk("rst_mid:mcause_kept", m_mcause, 32'd9);
            chk("rst_mid:mtval_untouched", m_mtval, prev_tval);
            for (int n = 0; n < 6; n++) begin
                @(negedge clk);
                #1 chk("rst_mid:no_redirect", {31'd0, redirect_valid}, 32'd0);
            end
            do_seq("after_reset", 1, 0, 32'd11, 32'hE0, 32'h77, 32'h2000, 5);
        end

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
